// File: rtl/mem_port_arbiter.sv
// Shares one single-ported backing memory between fetch and data requesters.
// Grants are registered: 1 cycle request-to-mem_req, and 1 cycle mem_ack-to-port ack.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  flush,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_D  = 2'd2;

    logic [1:0]            r_state;
    logic [SW-1:0]         r_streak;
    logic                  r_drop;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_if_ack;
    logic                  r_d_ack;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic w_if_elig;
    logic w_d_elig;
    logic w_grant_d;
    logic w_grant_if;

    // A port is masked in its own ack cycle so a held request is not re-granted.
    assign w_if_elig  = if_req & ~r_if_ack & ~flush;
    assign w_d_elig   = d_req & ~r_d_ack;
    assign w_grant_d  = w_d_elig & ~(w_if_elig & (r_streak == LIMIT));
    assign w_grant_if = w_if_elig & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_drop      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= S_BUSY_D;
                        r_mem_addr  <= d_addr;
                        r_mem_we    <= d_we;
                        r_mem_wdata <= d_wdata;
                        if (w_if_elig)
                            r_streak <= r_streak + SW'(1);
                    end else if (w_grant_if) begin
                        r_state    <= S_BUSY_IF;
                        r_mem_addr <= if_addr;
                        r_mem_we   <= 1'b0;
                        r_streak   <= '0;
                    end
                end
                S_BUSY_IF: begin
                    if (flush)
                        r_drop <= 1'b1;
                    // A flush landing on the ack cycle still suppresses the result.
                    if (mem_ack) begin
                        r_state  <= S_IDLE;
                        r_mem_we <= 1'b0;
                        r_drop   <= 1'b0;
                        if (!r_drop && !flush) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end
                    end
                end
                S_BUSY_D: begin
                    if (mem_ack) begin
                        r_state  <= S_IDLE;
                        r_mem_we <= 1'b0;
                        r_d_ack  <= 1'b1;
                        if (!r_mem_we)
                            r_d_rdata <= mem_rdata;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state != S_IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign stall_f   = ~rst & if_req & ~r_if_ack;
    assign stall_m   = ~rst & d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change 1ns after the rising edge
// and outputs are compared in the same window, well away from the next edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One starvation round: data grant, mem_ack, then a flush-masked d_ack cycle.
    task automatic data_round(input int i);
        cyc();
        check($sformatf("r%0d_req", i), {31'd0, mem_req}, 32'd1);
        check($sformatf("r%0d_we", i), {31'd0, mem_we}, 32'd0);
        check($sformatf("r%0d_addr", i), mem_addr, 32'h3000 + 32'(4 * i));
        mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(i);
        cyc();
        check($sformatf("r%0d_dack", i), {31'd0, d_ack}, 32'd1);
        check($sformatf("r%0d_drdata", i), d_rdata, 32'hA0 + 32'(i));
        mem_ack = 1'b0; flush = 1'b1; d_addr = 32'h3000 + 32'(4 * (i + 1));
        cyc();
        check($sformatf("r%0d_nogrant", i), {31'd0, mem_req}, 32'd0);
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state, stalls forced low while rst is high
        cyc(); cyc();
        if_req = 1'b1; d_req = 1'b1;
        #1;
        check("rst_stall_f", {31'd0, stall_f}, 32'd0);
        check("rst_stall_m", {31'd0, stall_m}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_d_ack", {31'd0, d_ack}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        d_req = 1'b0;

        // Fetch only, mem_ack on the third BUSY cycle
        rst = 1'b0; if_addr = 32'h100;
        #1;
        check("t1_stall_c0", {31'd0, stall_f}, 32'd1);
        cyc();
        check("t1_req_c1", {31'd0, mem_req}, 32'd1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_we", {31'd0, mem_we}, 32'd0);
        cyc();
        check("t1_req_c2", {31'd0, mem_req}, 32'd1);
        cyc();
        check("t1_req_c3", {31'd0, mem_req}, 32'd1);
        check("t1_stall_c3", {31'd0, stall_f}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        cyc();
        check("t1_if_ack", {31'd0, if_ack}, 32'd1);
        check("t1_if_rdata", if_rdata, 32'h00500093);
        check("t1_req_c4", {31'd0, mem_req}, 32'd0);
        check("t1_stall_c4", {31'd0, stall_f}, 32'd0);
        mem_ack = 1'b0; if_req = 1'b0;
        cyc();
        check("t1_ack_pulse", {31'd0, if_ack}, 32'd0);

        // Fetch and store together: data first, fetch in the d_ack cycle
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        cyc();
        check("t2_we", {31'd0, mem_we}, 32'd1);
        check("t2_addr", mem_addr, 32'h2000);
        check("t2_wdata", mem_wdata, 32'hDEADBEEF);
        check("t2_stall_m", {31'd0, stall_m}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        cyc();
        check("t2_d_ack", {31'd0, d_ack}, 32'd1);
        check("t2_d_rdata_hold", d_rdata, 32'd0);
        check("t2_we_clr", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b0; d_req = 1'b0;
        cyc();
        check("t2_f_req", {31'd0, mem_req}, 32'd1);
        check("t2_f_addr", mem_addr, 32'h104);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        cyc();
        check("t2_if_ack", {31'd0, if_ack}, 32'd1);
        check("t2_if_rdata", if_rdata, 32'h11111111);
        mem_ack = 1'b0; if_req = 1'b0;
        cyc();

        // Starvation: fetch kept out of the d_ack cycles by flush, data wins 4 times
        if_req = 1'b1; if_addr = 32'h108;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        for (int i = 0; i < 4; i++) data_round(i);
        cyc();
        check("t3_force_addr", mem_addr, 32'h108);
        check("t3_force_we", {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        cyc();
        check("t3_if_ack", {31'd0, if_ack}, 32'd1);
        check("t3_if_rdata", if_rdata, 32'h0BADF00D);
        mem_ack = 1'b0; if_req = 1'b0;
        cyc();
        check("t3_resume_addr", mem_addr, 32'h3010);
        mem_ack = 1'b1; mem_rdata = 32'hA4;
        if_req = 1'b1; if_addr = 32'h10C; d_addr = 32'h3014;
        cyc();
        check("t3_resume_rdata", d_rdata, 32'hA4);
        mem_ack = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        // Streak was cleared, so data beats the waiting fetch again
        check("t3_streak_clr", mem_addr, 32'h3014);
        mem_ack = 1'b1; mem_rdata = 32'hA5;
        cyc();
        check("t3_last_dack", {31'd0, d_ack}, 32'd1);
        mem_ack = 1'b0; d_req = 1'b0;
        cyc();
        check("t5_f_addr", mem_addr, 32'h10C);
        // Flush on the mem_ack cycle of a fetch
        mem_ack = 1'b1; mem_rdata = 32'h22222222; flush = 1'b1;
        cyc();
        check("t5_no_ack", {31'd0, if_ack}, 32'd0);
        check("t5_rdata_hold", if_rdata, 32'h0BADF00D);
        check("t5_idle", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0; flush = 1'b0; if_req = 1'b0;
        cyc();

        // Flush mid-transaction, then the redirected fetch
        if_req = 1'b1; if_addr = 32'h180;
        cyc();
        check("t4_addr", mem_addr, 32'h180);
        flush = 1'b1; if_addr = 32'h200;
        cyc();
        flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33333333;
        cyc();
        check("t4_no_ack", {31'd0, if_ack}, 32'd0);
        check("t4_rdata_hold", if_rdata, 32'h0BADF00D);
        mem_ack = 1'b0;
        cyc();
        check("t4_new_req", {31'd0, mem_req}, 32'd1);
        check("t4_new_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h44444444;
        cyc();
        check("t4_if_ack", {31'd0, if_ack}, 32'd1);
        check("t4_if_rdata", if_rdata, 32'h44444444);
        mem_ack = 1'b0; if_req = 1'b0;
        cyc();

        // Flush with a new request in IDLE blocks the grant for that cycle
        if_req = 1'b1; if_addr = 32'h300; flush = 1'b1;
        cyc();
        check("t5_flush_idle", {31'd0, mem_req}, 32'd0);
        flush = 1'b0;
        cyc();
        check("t5_late_grant", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h0;
        cyc();
        mem_ack = 1'b0; if_req = 1'b0;
        cyc();

        // Reset during a store with no mem_ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'h55AA55AA;
        cyc();
        check("t6_we", {31'd0, mem_we}, 32'd1);
        check("t6_wdata", mem_wdata, 32'h55AA55AA);
        cyc();
        rst = 1'b1;
        #1;
        check("t6_stall_m_rst", {31'd0, stall_m}, 32'd0);
        cyc();
        check("t6_req", {31'd0, mem_req}, 32'd0);
        check("t6_we_clr", {31'd0, mem_we}, 32'd0);
        check("t6_addr", mem_addr, 32'd0);
        check("t6_wdata_clr", mem_wdata, 32'd0);
        check("t6_if_rdata", if_rdata, 32'd0);
        check("t6_d_rdata", d_rdata, 32'd0);
        rst = 1'b0; d_we = 1'b0; d_addr = 32'h4004;
        cyc();
        check("t6_load_addr", mem_addr, 32'h4004);
        mem_ack = 1'b1; mem_rdata = 32'h66778899;
        cyc();
        check("t6_d_ack", {31'd0, d_ack}, 32'd1);
        check("t6_load_data", d_rdata, 32'h66778899);
        mem_ack = 1'b0; d_req = 1'b0;
        cyc();

        // Stray mem_ack in IDLE
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        cyc();
        mem_ack = 1'b0;
        check("idle_ack_if", {31'd0, if_ack}, 32'd0);
        check("idle_ack_d", {31'd0, d_ack}, 32'd0);
        check("idle_ack_drdata", d_rdata, 32'h66778899);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It owns the request/acknowledge handshake to a variable-latency backing memory and generates the fetch and memory-stage stall signals consumed by the pipeline registers and hazard logic. Fetch results can be discarded on a branch flush without aborting the memory transaction.

## Interface

- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width on all ports
- STARVE_LIMIT, 4, consecutive data grants won over a waiting fetch before fetch is forced ahead (≥1)

One clock; reset is synchronous and active-high.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle pulse: fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data, valid while if_ack=1
- flush  in  1  branch taken in execute; cancel fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_WIDTH  load data, valid while d_ack=1 and access was a load
- stall_f  out  1  fetch waiting (if_req & ~if_ack)
- stall_m  out  1  data waiting (d_req & ~d_ack)
- mem_req  out  1  backing memory request
- mem_we  out  1  backing memory write enable
- mem_addr  out  ADDR_WIDTH  backing memory address
- mem_wdata  out  DATA_WIDTH  backing memory write data
- mem_ack  in  1  backing memory completion, one cycle; read data valid same cycle
- mem_rdata  in  DATA_WIDTH  backing memory read data

## Operation

- States: IDLE, BUSY_IF, BUSY_D. mem_req = (state != IDLE).
- IDLE arbitration, per cycle. Eligible fetch = if_req & ~if_ack & ~flush. Eligible data = d_req & ~d_ack.
  - Only one eligible: grant it.
  - Both eligible: grant data, unless streak == STARVE_LIMIT, in which case grant fetch.
- On grant: latch the address, plus d_we/d_wdata for a data grant, into mem_addr/mem_we/mem_wdata, and go to BUSY_IF or BUSY_D. These outputs stay stable for the whole BUSY state.
- streak counter, width clog2(STARVE_LIMIT+1):
  - increments on a data grant while fetch is eligible;
  - clears on any fetch grant;
  - otherwise holds; never exceeds STARVE_LIMIT.
- BUSY_x with mem_ack=1: next cycle return to IDLE and clear mem_we; mem_addr holds its last value.
  - Data: d_ack pulses for one cycle. d_rdata <= mem_rdata on a load; holds on a store.
  - Fetch: if_ack pulses and if_rdata <= mem_rdata, unless the drop flag is set.
- Drop flag:
  - set by flush=1 in any BUSY_IF cycle, including the mem_ack cycle;
  - when set, the transaction completes on the memory side, if_ack stays 0 and if_rdata holds;
  - cleared on return to IDLE.
- Flush never affects data transactions.
- A port's request is ignored in the cycle its ack is high. The requester deasserts or changes its request in that cycle.
- stall_f and stall_m are combinational from the inputs and ack registers. Both are forced to 0 while rst=1.

## Timing

- Reset (rst=1 at an edge): state IDLE, streak 0, drop 0. mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata and d_rdata are all 0.
- Reset mid-transaction abandons it with no ack. The backing memory is reset by the same rst.
- Grant latency: a request eligible in IDLE at cycle N gives mem_req=1 from cycle N+1.
- Completion: mem_ack at cycle K gives x_ack=1 at cycle K+1, with state IDLE in K+1.
- Minimum transaction (mem_ack in first BUSY cycle): request at N, ack at N+2. Back-to-back grants every 2 cycles.
- Simultaneous events:
  - flush and if_req in the same IDLE cycle: no fetch grant.
  - d_ack cycle with if_req pending: fetch granted that cycle (data masked).
- mem_ack while in IDLE is ignored.

## Test plan

- Fetch only, if_addr=0x100, mem_ack after 3 BUSY cycles with mem_rdata=0x00500093 -> mem_req cycles 1–3, mem_addr=0x100, mem_we=0, if_ack and if_rdata=0x00500093 at cycle 4, stall_f=1 cycles 0–3.
- Both requesting in the same cycle: fetch 0x104, store 0x2000 with wdata 0xDEADBEEF -> data granted first (mem_we=1, mem_addr=0x2000); fetch granted in the d_ack cycle; if_ack follows; d_rdata unchanged.
- Data held continuously (loads to 0x3000+4i) with fetch pending, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then streak=0 and data resumes.
- Fetch in BUSY_IF, flush=1 for one cycle mid-transaction -> mem_ack still consumed, no if_ack, if_rdata holds the previous value; the new if_req to 0x200 is then granted normally.
- Flush asserted in the same cycle as mem_ack for a fetch -> no if_ack. Flush asserted together with a new if_req in IDLE -> no grant that cycle.
- rst asserted during BUSY_D with mem_ack never returned -> next cycle all outputs 0, state IDLE; a subsequent load completes with correct d_rdata.
